aes_job_arbiter: RTL and testbench

//  Shares one AES-256 en/decrypt core between two requesters (signer, verifier) of the signature authenticator.

---
 rtl/aes_arb_pkg.sv | 19 +
 rtl/aes_job_arbiter_if.sv | 35 +++
 rtl/rr_arb2.sv | 18 +
 rtl/aes_job_arbiter.sv | 116 +++++++++++
 tb/tb_aes_job_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_arb_pkg.sv
// Shared constants and state encoding for the two-requester AES job arbiter.
package aes_arb_pkg;

  localparam int KEY_BW      = 256;
  localparam int TXT_BW      = 128;
  localparam int N_REQ       = 2;
  localparam int TIMEOUT_DEF = 64;
  // Timer must be able to hold TIMEOUT_CYC-1 for any timeout the top is built with.
  localparam int TMR_BW      = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_BUSY    = 3'd2,
    ST_RECOVER = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/aes_job_arbiter_if.sv
// Request/response and AES-core signals of the job arbiter, bundled with
// master (requesters plus core) and slave (arbiter) views.
interface aes_job_arbiter_if;
  import aes_arb_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_mode;
  logic [N_REQ*KEY_BW-1:0] req_key;
  logic [N_REQ*TXT_BW-1:0] req_word;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [TXT_BW-1:0]       rsp_data;
  logic                    rsp_err;
  logic                    aes_enable;
  logic                    aes_mode;
  logic [KEY_BW-1:0]       aes_key;
  logic [TXT_BW-1:0]       aes_word;
  logic                    aes_srst_n;
  logic [TXT_BW-1:0]       aes_result;
  logic                    aes_done;

  modport master (
    output req_valid, req_mode, req_key, req_word, rsp_ready, aes_result, aes_done,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  aes_enable, aes_mode, aes_key, aes_word, aes_srst_n
  );

  modport slave (
    input  req_valid, req_mode, req_key, req_word, rsp_ready, aes_result, aes_done,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output aes_enable, aes_mode, aes_key, aes_word, aes_srst_n
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one AES core between two requesters: round-robin accept, one-cycle
// launch, wait for done (with watchdog abort and core reset), return result.
module aes_job_arbiter
  import aes_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst,
  aes_job_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        gnt;
  logic              gsel;
  logic              accept;
  logic              timeout;
  logic              last;
  logic              owner;
  logic [TMR_BW-1:0] timer;
  logic              job_mode;
  logic [KEY_BW-1:0] job_key;
  logic [TXT_BW-1:0] job_word;
  logic [TXT_BW-1:0] res_data;
  logic              res_err;
  logic              core_srst_n;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic              aes_enable;

  rr_arb2 u_arb (
    .req  (bus.req_valid),
    .last (last),
    .gnt  (gnt)
  );

  assign gsel    = gnt[1];
  assign accept  = (state == ST_IDLE) && (gnt != 2'b00);
  assign timeout = (timer == TMR_BW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    state_nxt = accept ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH:  state_nxt = ST_BUSY;
      // A done arriving on the timeout cycle still counts as success.
      ST_BUSY: begin
        if (bus.aes_done)  state_nxt = ST_RESP;
        else if (timeout)  state_nxt = ST_RECOVER;
        else               state_nxt = ST_BUSY;
      end
      ST_RECOVER: state_nxt = ST_RESP;
      ST_RESP:    state_nxt = bus.rsp_ready[owner] ? ST_IDLE : ST_RESP;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE) ? gnt : 2'b00;
    rsp_valid  = (state == ST_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    aes_enable = (state == ST_LAUNCH);
  end

  // Core reset is low throughout rst and for the single RECOVER cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) core_srst_n <= 1'b0;
    else     core_srst_n <= (state_nxt != ST_RECOVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_mode <= 1'b0;
      job_key  <= {KEY_BW{1'b0}};
      job_word <= {TXT_BW{1'b0}};
      owner    <= 1'b0;
      last     <= 1'b1;
      timer    <= {TMR_BW{1'b0}};
      res_data <= {TXT_BW{1'b0}};
      res_err  <= 1'b0;
    end else begin
      if (accept) begin
        job_mode <= bus.req_mode[gsel];
        job_key  <= gsel ? bus.req_key[2*KEY_BW-1:KEY_BW] : bus.req_key[KEY_BW-1:0];
        job_word <= gsel ? bus.req_word[2*TXT_BW-1:TXT_BW] : bus.req_word[TXT_BW-1:0];
        owner    <= gsel;
      end
      if (state == ST_LAUNCH)    timer <= {TMR_BW{1'b0}};
      else if (state == ST_BUSY) timer <= timer + TMR_BW'(1);
      if (state == ST_BUSY && bus.aes_done) begin
        res_data <= bus.aes_result;
        res_err  <= 1'b0;
      end else if (state == ST_BUSY && timeout) begin
        res_data <= {TXT_BW{1'b0}};
        res_err  <= 1'b1;
      end
      if (state == ST_RESP && bus.rsp_ready[owner]) last <= owner;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_data   = res_data;
  assign bus.rsp_err    = res_err;
  assign bus.aes_enable = aes_enable;
  assign bus.aes_mode   = job_mode;
  assign bus.aes_key    = job_key;
  assign bus.aes_word   = job_word;
  assign bus.aes_srst_n = core_srst_n;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench for aes_job_arbiter with a behavioural stand-in for the AES core.
module tb_aes_job_arbiter;
  import aes_arb_pkg::*;

  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_job_arbiter_if bus ();

  aes_job_arbiter #(.TIMEOUT_CYC(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int last_served = 1;

  // Core stand-in: FIPS-197 vector pair for KEY, an arbitrary mix otherwise.
  function automatic logic [127:0] core_fn(input logic mode, input logic [255:0] key, input logic [127:0] word);
    if (key == KEY && !mode && word == PT) return CT;
    if (key == KEY && mode && word == CT) return PT;
    return {word[63:0], word[127:64]} ^ key[127:0] ^ key[255:128] ^ {128{mode}};
  endfunction

  int           core_lat  = 10;
  bit           core_hang = 1'b0;
  logic         spur_done = 1'b0;
  logic         core_busy;
  int           core_cnt;
  logic         core_done;
  logic [127:0] core_res;

  always @(posedge clk) begin
    if (!bus.aes_srst_n) begin
      core_busy <= 1'b0;
      core_done <= 1'b0;
      core_res  <= 128'h0;
      core_cnt  <= 0;
    end else begin
      core_done <= 1'b0;
      if (bus.aes_enable) begin
        core_busy <= 1'b1;
        core_cnt  <= core_lat;
        core_res  <= core_fn(bus.aes_mode, bus.aes_key, bus.aes_word);
      end else if (core_busy && !core_hang) begin
        if (core_cnt <= 1) begin
          core_done <= 1'b1;
          core_busy <= 1'b0;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  assign bus.aes_done   = core_done | spur_done;
  assign bus.aes_result = core_res;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference arbitration: a lone requester wins; on contention the one not served last.
  function automatic int pick(input logic [1:0] v);
    if (v == 2'b11) return (last_served == 0) ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    last_served = 1;
  endtask

  // One complete job: present, accept, wait for response, optional backpressure, consume.
  task automatic serve(input string nm, input logic [1:0] vmask, input int g, input logic [127:0] exp_d,
                       input logic exp_e, input int exp_lat, input int exp_lows, input int hold);
    logic [1:0] oh;
    int n;
    int enables;
    int lows;
    logic stable;
    oh = (g == 1) ? 2'b10 : 2'b01;
    bus.req_valid = vmask;
    #1;
    chk({nm, "_ready"}, bus.req_ready, oh);
    @(negedge clk);
    bus.req_valid = 2'b00;
    chk({nm, "_enable"}, bus.aes_enable, 1'b1);
    n = 0;
    enables = 1;
    lows = 0;
    while (bus.rsp_valid == 2'b00 && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.aes_enable) enables++;
      if (!bus.aes_srst_n) lows++;
    end
    chk({nm, "_latency"}, n, exp_lat);
    chk({nm, "_enables"}, enables, 1);
    chk({nm, "_srst_lows"}, lows, exp_lows);
    chk({nm, "_rsp_valid"}, bus.rsp_valid, oh);
    chk({nm, "_data"}, bus.rsp_data, exp_d);
    chk({nm, "_err"}, bus.rsp_err, exp_e);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready = ~oh;
      bus.req_valid = ~oh;
      @(negedge clk);
      if (bus.rsp_valid !== oh || bus.rsp_data !== exp_d || bus.rsp_err !== exp_e ||
          bus.req_ready !== 2'b00 || bus.aes_enable !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk({nm, "_hold"}, stable, 1'b1);
    bus.req_valid = 2'b00;
    bus.rsp_ready = oh;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    chk({nm, "_release"}, bus.rsp_valid, 2'b00);
    last_served = g;
  endtask

  typedef struct {
    logic [1:0]   vmask;
    logic [1:0]   mode;
    logic [127:0] w0;
    logic [127:0] w1;
    int           lat;
    bit           hang;
    int           hold;
    int           g;
    logic [127:0] exp_d;
    bit           exp_e;
    int           exp_lat;
    int           exp_lows;
  } vec_t;

  vec_t tbl[9];
  int   exp_ord[3] = '{0, 1, 0};

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic saw;
    logic [1:0] vm;
    logic [1:0] md;
    logic [255:0] k0;
    logic [255:0] k1;
    logic [127:0] w0;
    logic [127:0] w1;
    int lat;
    int hold;
    int g;
    logic [127:0] ed;

    // vmask mode w0 w1 lat hang hold owner data err latency srst_lows
    tbl[0] = '{2'b01, 2'b00, PT, PT,  10, 1'b0,  0, 0, CT,     1'b0, 12, 0};
    tbl[1] = '{2'b10, 2'b10, PT, CT,   5, 1'b0,  0, 1, PT,     1'b0,  7, 0};
    tbl[2] = '{2'b11, 2'b10, PT, CT,   3, 1'b0, 20, 0, CT,     1'b0,  5, 0};
    tbl[3] = '{2'b11, 2'b10, PT, CT,   8, 1'b0,  0, 1, PT,     1'b0, 10, 0};
    tbl[4] = '{2'b01, 2'b00, PT, PT,  10, 1'b1,  0, 0, 128'h0, 1'b1, 66, 1};
    tbl[5] = '{2'b10, 2'b10, PT, CT,   2, 1'b0,  0, 1, PT,     1'b0,  4, 0};
    tbl[6] = '{2'b01, 2'b00, PT, PT,  63, 1'b0,  0, 0, CT,     1'b0, 65, 0};
    tbl[7] = '{2'b01, 2'b00, PT, PT,  64, 1'b0,  0, 0, 128'h0, 1'b1, 66, 1};
    tbl[8] = '{2'b11, 2'b11, CT, CT,   1, 1'b0,  0, 1, PT,     1'b0,  3, 0};

    bus.req_valid = 2'b00;
    bus.req_mode  = 2'b00;
    bus.req_key   = 512'h0;
    bus.req_word  = 256'h0;
    bus.rsp_ready = 2'b00;

    repeat (2) @(negedge clk);
    chk("reset_ctl", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.aes_enable, bus.aes_mode, bus.aes_srst_n}, 8'h00);
    chk("reset_data", bus.rsp_data, 128'h0);
    chk("reset_key", bus.aes_key, 256'h0);
    chk("reset_word", bus.aes_word, 128'h0);
    rst = 1'b0;
    #1;
    chk("srst_at_release", bus.aes_srst_n, 1'b0);
    @(negedge clk);
    chk("srst_after_release", bus.aes_srst_n, 1'b1);
    last_served = 1;

    for (int i = 0; i < 9; i++) begin
      bus.req_mode = tbl[i].mode;
      bus.req_key  = {KEY, KEY};
      bus.req_word = {tbl[i].w1, tbl[i].w0};
      core_lat     = tbl[i].lat;
      core_hang    = tbl[i].hang;
      serve($sformatf("vec%0d", i), tbl[i].vmask, tbl[i].g, tbl[i].exp_d, tbl[i].exp_e,
            tbl[i].exp_lat, tbl[i].exp_lows, tbl[i].hold);
      core_hang = 1'b0;
    end

    // Both requesters held valid across three jobs.
    do_reset();
    bus.req_mode  = 2'b10;
    bus.req_key   = {KEY, KEY};
    bus.req_word  = {CT, PT};
    core_lat      = 4;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (bus.rsp_valid == 2'b00 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("order%0d", k), bus.rsp_valid, (exp_ord[k] == 1) ? 2'b10 : 2'b01);
      chk($sformatf("order%0d_data", k), bus.rsp_data, (exp_ord[k] == 1) ? PT : CT);
      bus.rsp_ready = (exp_ord[k] == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      if (k == 2) bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      last_served = exp_ord[k];
    end

    // Reset in the middle of a job for requester 1.
    bus.req_mode = 2'b00;
    bus.req_word = {PT, PT};
    core_lat = 10;
    serve("pre_rst", 2'b01, 0, CT, 1'b0, 12, 0, 0);
    bus.req_mode  = 2'b10;
    bus.req_word  = {CT, PT};
    core_lat      = 30;
    bus.req_valid = 2'b10;
    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ctl", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.aes_enable, bus.aes_mode, bus.aes_srst_n}, 8'h00);
    chk("midrst_data", bus.rsp_data, 128'h0);
    chk("midrst_key", bus.aes_key, 256'h0);
    chk("midrst_word", bus.aes_word, 128'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spur_done = 1'b1;
    last_served = 1;
    #1;
    chk("midrst_srst_release", bus.aes_srst_n, 1'b0);
    @(negedge clk);
    chk("midrst_srst_rise", bus.aes_srst_n, 1'b1);
    spur_done = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) saw = 1'b1;
    end
    chk("stale_done_ignored", saw, 1'b0);
    core_lat = 5;
    serve("after_rst", 2'b11, 0, CT, 1'b0, 7, 0, 0);

    // Random jobs against the reference arbitration and core models.
    for (int it = 0; it < 25; it++) begin
      vm   = 2'($urandom_range(1, 3));
      md   = 2'($urandom_range(0, 3));
      k0   = {rand128(), rand128()};
      k1   = {rand128(), rand128()};
      w0   = rand128();
      w1   = rand128();
      lat  = $urandom_range(1, 15);
      hold = $urandom_range(0, 3);
      g    = pick(vm);
      ed   = (g == 1) ? core_fn(md[1], k1, w1) : core_fn(md[0], k0, w0);
      bus.req_mode = md;
      bus.req_key  = {k1, k0};
      bus.req_word = {w1, w0};
      core_lat     = lat;
      serve($sformatf("rnd%0d", it), vm, g, ed, 1'b0, lat + 2, 0, hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
